mux_scan_seq: RTL
=================

MUX_SCAN_SEQ -- requirements
Module: mux_scan_seq

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, range 2..64.
REQ-002 Parameter DW, default 1: data width per channel, range 1..32.
REQ-003 Parameter DWELL_W, default 8: width of the dwell counter and of the dwell input.
REQ-004 Derived SW = clog2(N_CH): width of the select and channel fields.
REQ-005 clk  input  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, synchronous and active-low.
REQ-007 d  input  N_CH*DW  packed channel data; channel k occupies bits [k*DW +: DW].
REQ-008 sel  input  SW  manual channel select, used only when mode=0.
REQ-009 mode  input  1  0 = manual select; 1 = auto-scan.
REQ-010 start  input  1  single-cycle pulse that begins a scan; ignored when mode=0.
REQ-011 stop  input  1  single-cycle pulse that ends a scan.
REQ-012 dwell  input  DWELL_W  cycles per channel minus one; sampled at scan start and at each channel advance.
REQ-013 y  output  DW  registered selected data.
REQ-014 ch  output  SW  registered index of the channel currently driving y.
REQ-015 busy  output  1  high while the FSM is in SCAN.
REQ-016 wrap  output  1  one-cycle pulse when the scan advances from channel N_CH-1 to channel 0.
REQ-017 sel_err  output  1  registered flag: manual sel >= N_CH.

Function
REQ-018 The FSM shall have states IDLE and SCAN; reset state is IDLE.
REQ-019 Every cycle, y shall load the d slice of the channel that ch loads on the same edge, so that y and ch are always coherent.
REQ-020 Latency from d to y shall be 1 cycle; y shall track d continuously while ch is held.
REQ-021 Manual mode (mode=0): ch <= sel, y <= d[sel], 1-cycle latency; the FSM shall remain in or be forced to IDLE.
REQ-022 Manual out-of-range (sel >= N_CH): y <= 0, ch <= sel, sel_err <= 1; otherwise sel_err <= 0.
REQ-023 sel_err shall be 0 whenever mode=1.
REQ-024 IDLE with mode=1 and start=1: the FSM shall enter SCAN, ch <= 0, and the dwell counter <= dwell.
REQ-025 IDLE with mode=1 and no start: ch and the dwell counter shall hold; y shall continue to track d[ch].
REQ-026 SCAN with counter > 0: the counter shall decrement by 1 and ch shall hold.
REQ-027 SCAN with counter = 0: ch shall advance by 1 and the counter shall reload from the current dwell.
REQ-028 Channel dwell time in SCAN shall be exactly dwell+1 cycles; dwell=0 advances every cycle.
REQ-029 Wrap-around: when counter = 0 and ch = N_CH-1, ch <= 0 and wrap <= 1 for one cycle; wrap = 0 at all other times.
REQ-030 SCAN with stop=1: the FSM shall go to IDLE, ch shall hold its current value, and no advance or wrap shall occur that cycle.
REQ-031 start and stop asserted in the same cycle: stop wins; the FSM shall be in or remain in IDLE.
REQ-032 start while already in SCAN shall restart the scan: ch <= 0 and the counter <= dwell; wrap shall not pulse.
REQ-033 mode falling 1->0 during SCAN: the FSM shall go to IDLE and manual behaviour shall apply on the same edge.
REQ-034 busy shall be 1 exactly when the registered state is SCAN.
REQ-035 A change in dwell during SCAN shall take effect only at the next reload.

Reset
REQ-036 On rst_n=0 at a rising edge: state <= IDLE, y <= 0, ch <= 0, counter <= 0, busy <= 0, wrap <= 0, sel_err <= 0.
REQ-037 Reset shall take priority over every other input, including when asserted mid-scan.
REQ-038 Outputs shall not change asynchronously to clk.

Verification
REQ-039 Manual sweep, N_CH=8, DW=1, mode=0, sel=0..7 with d=8'b1010_0110: after 1 cycle y=d[sel] and ch=sel; sel_err=0.
REQ-040 Out-of-range check, N_CH=6, sel=7: the next cycle gives y=0 and sel_err=1; sel=2 then clears sel_err.
REQ-041 Scan, dwell=2, start pulse: ch runs 0,0,0,1,1,1,...,7,7,7,0; wrap is high exactly on the edge where ch goes 7->0; busy=1 throughout.
REQ-042 dwell=0 scan, then stop pulsed while ch=5: ch stays 5, busy=0 the next cycle, no wrap; start then restarts the scan at ch=0.
REQ-043 start and stop in the same cycle from IDLE: busy stays 0; rst_n=0 while ch=4 in SCAN: the next cycle gives ch=0, y=0, busy=0.
REQ-044 Data tracking, DW=8, dwell=3 on ch=2: changing d[2] each cycle is reflected on y one cycle later.

Source files
------------

// File: rtl/mux_scan_seq.sv
// mux_scan_seq: registered N_CH-way data multiplexer with a manual-select
// mode and an auto-scan mode that dwells dwell+1 cycles on each channel.
//
// Handshake: there is no valid/ready channel here. start and stop are
// single-cycle pulses sampled on the rising edge. Outputs y/ch/wrap/sel_err
// are registered. busy is decoded from the registered FSM state only.
module mux_scan_seq #(
    parameter int N_CH    = 8,
    parameter int DW      = 1,
    parameter int DWELL_W = 8,
    localparam int SW     = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_CH*DW-1:0]   d,
    input  logic [SW-1:0]        sel,
    input  logic                 mode,
    input  logic                 start,
    input  logic                 stop,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [DW-1:0]        y,
    output logic [SW-1:0]        ch,
    output logic                 busy,
    output logic                 wrap,
    output logic                 sel_err
);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t             state_q;
    state_t             state_n;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] cnt_n;
    logic [SW-1:0]      ch_n;
    logic               wrap_n;
    logic               err_n;
    logic [DW-1:0]      y_n;
    logic               sel_oor;

    // Manual select beyond the last channel (only possible when N_CH is not a power of two).
    assign sel_oor = ({1'b0, sel} >= (SW + 1)'(N_CH));

    // Next-state decode: manual mode first, then stop over start, then scan stepping.
    always_comb begin
        state_n = state_q;
        ch_n    = ch;
        cnt_n   = cnt_q;
        wrap_n  = 1'b0;
        err_n   = 1'b0;
        if (!mode) begin
            state_n = IDLE;
            ch_n    = sel;
            err_n   = sel_oor;
        end else if (stop) begin
            state_n = IDLE;
        end else if (start) begin
            state_n = SCAN;
            ch_n    = '0;
            cnt_n   = dwell;
        end else if (state_q == SCAN) begin
            if (cnt_q != '0) begin
                cnt_n = cnt_q - DWELL_W'(1);
            end else begin
                cnt_n = dwell;
                if (ch == SW'(N_CH - 1)) begin
                    ch_n   = '0;
                    wrap_n = 1'b1;
                end else begin
                    ch_n = ch + SW'(1);
                end
            end
        end
    end

    // Data slice of the channel that ch loads on this edge; out-of-range selects give zero.
    always_comb begin
        y_n = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (ch_n == SW'(k)) begin
                y_n = d[k*DW +: DW];
            end
        end
    end

    // Single registered FSM with registered outputs; reset overrides everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ch      <= '0;
            y       <= '0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            ch      <= ch_n;
            y       <= y_n;
            wrap    <= wrap_n;
            sel_err <= err_n;
        end
    end

    assign busy = (state_q == SCAN);

endmodule
